mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low; 0 = in reset.
REQ-003 SHALL have port: req_valid  input  1  core-side access request.
REQ-004 SHALL have port: req_ready  output  1  request accepted when req_valid & req_ready at rising edge.
REQ-005 SHALL have port: req_write  input  1  1 = store, 0 = load.
REQ-006 SHALL have port: req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 SHALL have port: req_signed  input  1  loads: 1 = sign-extend, 0 = zero-extend.
REQ-008 SHALL have port: req_addr  input  32  byte address.
REQ-009 SHALL have port: req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port: address  output  32  bus address, always word-aligned (bits [1:0] = 00).
REQ-011 SHALL have port: read  output  1  bus read strobe.
REQ-012 SHALL have port: write  output  1  bus write strobe.
REQ-013 SHALL have port: waitrequest  input  1  responder stall; strobe accepted at a rising edge where waitrequest = 0.
REQ-014 SHALL have port: byteenable  output  4  lane i = byte at address+i (little-endian).
REQ-015 SHALL have port: writedata  output  32  lane-aligned store data.
REQ-016 SHALL have port: readdata  input  32  valid during the cycle after read acceptance.
REQ-017 SHALL have port: resp_valid  output  1  single-cycle completion pulse; no backpressure.
REQ-018 SHALL have port: resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-019 SHALL have port: resp_err  output  1  qualifies resp_valid; misaligned or illegal-size access.

Function
REQ-020 SHALL implement FSM states IDLE, BUS, RDCAP, RESP; req_ready = 1 only in IDLE.
REQ-021 On acceptance, SHALL register addr/size/signed/wdata; legal access -> BUS; illegal -> RESP with err.
REQ-022 Legality: byte any offset; half offset 0 or 2; word offset 0; size 11 always illegal.
REQ-023 In BUS, SHALL drive exactly one of read/write with address = {req_addr[31:2],2'b00}; all bus outputs registered and held stable while waitrequest = 1.
REQ-024 Byteenable: byte -> 1<<off; half off0 -> 0011, off2 -> 1100; word -> 1111.
REQ-025 Writedata: byte -> data[7:0] replicated on all 4 lanes; half -> data[15:0] on both halves; word -> data unchanged.
REQ-026 Store: at BUS edge with waitrequest = 0 -> RESP; write deasserts next cycle.
REQ-027 Load: at BUS edge with waitrequest = 0 -> RDCAP; read deasserts; readdata captured at end of RDCAP -> RESP.
REQ-028 Load extract: shift readdata right by 8*off, take 8/16/32 bits, extend per req_signed.
REQ-029 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE.
REQ-030 Latency with waitrequest = 0: store resp_valid 2 cycles after acceptance edge; load 3; error 1.
REQ-031 Each waitrequest-high cycle in BUS SHALL add exactly one cycle of latency; no timeout.
REQ-032 read and write SHALL never be asserted together, nor outside BUS.

Reset
REQ-033 While reset = 0, SHALL force state IDLE, read = write = resp_valid = resp_err = 0, byteenable = 0, address = writedata = resp_rdata = 0, req_ready = 0.
REQ-034 Reset assertion mid-transaction SHALL drop read/write immediately (asynchronously) and emit no response for the aborted access.
REQ-035 After reset release, req_ready SHALL be 1 from the first rising edge.

Verification
REQ-036 SW: addr 0x10, data 0xAABBCCDD, waitrequest 0 -> one write cycle, address 0x10, byteenable 1111, writedata 0xAABBCCDD; resp_valid 2 cycles after acceptance, err 0.
REQ-037 LB: addr 0x13, memory word 0x80FF1234 -> read, byteenable 1000; signed resp_rdata 0xFFFFFF80, unsigned 0x00000080, 3-cycle latency.
REQ-038 SH: addr 0x22, data 0x0000CCDD, waitrequest high 3 cycles -> address 0x20, byteenable 1100, writedata 0xCCDDCCDD stable 4 cycles; resp_valid 5 cycles after acceptance.
REQ-039 LW: addr 0x06 -> no read/write ever; resp_valid & resp_err one cycle after acceptance; resp_rdata 0.
REQ-040 Reset low during stalled read -> read = 0 same cycle, no resp_valid; after release, LH at 0x02 of word 0x8001ABCD, signed -> 0xFFFF8001.
REQ-041 Back-to-back: req_valid held for SW then LW -> second accepted the cycle after first resp_valid; strobes never overlap.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: core load/store requests to a word-aligned, stallable memory bus
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    typedef enum logic [1:0] {IDLE, BUS, RDCAP, RESP} state_t;

    state_t      r_state, w_next;
    logic [31:2] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata, r_rdata;
    logic        r_read, r_write, r_err, r_signed;
    logic [1:0]  r_off, r_size;
    logic        w_accept, w_legal, w_bus_done;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_shift, w_ext;

    assign req_ready  = (r_state == IDLE) & reset;
    assign w_accept   = req_valid & req_ready;
    assign w_bus_done = (r_state == BUS) & ~waitrequest;
    assign address    = {r_addr, 2'b00};
    assign read       = r_read;
    assign write      = r_write;
    assign byteenable = r_be;
    assign writedata  = r_wdata;
    assign resp_valid = (r_state == RESP);
    assign resp_err   = resp_valid & r_err;
    assign resp_rdata = resp_valid ? r_rdata : 32'h0;

    // Request decode: alignment check, lane enables and lane-replicated store data
    always_comb begin
        w_legal = (req_size == 2'b00) | ((req_size == 2'b01) & ~req_addr[0]) |
                  ((req_size == 2'b10) & (req_addr[1:0] == 2'b00));
        w_be    = (req_size == 2'b00) ? 4'b0001 << req_addr[1:0] :
                  (req_size == 2'b01) ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        w_wdata = (req_size == 2'b00) ? {4{req_wdata[7:0]}} :
                  (req_size == 2'b01) ? {2{req_wdata[15:0]}} : req_wdata;
    end

    // Load extraction: move the addressed bytes to bit 0 and extend
    always_comb begin
        w_shift = readdata >> {r_off, 3'b000};
        w_ext   = (r_size == 2'b00) ? {{24{r_signed & w_shift[7]}}, w_shift[7:0]} :
                  (r_size == 2'b01) ? {{16{r_signed & w_shift[15]}}, w_shift[15:0]} : w_shift;
    end

    // State register; reset aborts any access in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? (w_legal ? BUS : RESP) : IDLE;
            BUS:     w_next = w_bus_done ? (r_write ? RESP : RDCAP) : BUS;
            RDCAP:   w_next = RESP;
            default: w_next = IDLE;
        endcase
    end

    // Registered bus outputs and request context; strobes drop on bus acceptance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr   <= '0;
            r_be     <= '0;
            r_wdata  <= '0;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
            r_off    <= '0;
            r_size   <= '0;
            r_signed <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_accept) begin
                r_addr   <= req_addr[31:2];
                r_be     <= w_be;
                r_wdata  <= w_wdata;
                r_read   <= w_legal & ~req_write;
                r_write  <= w_legal & req_write;
                r_err    <= ~w_legal;
                r_off    <= req_addr[1:0];
                r_size   <= req_size;
                r_signed <= req_signed;
                r_rdata  <= '0;
            end
            if (w_bus_done) begin
                r_read  <= 1'b0;
                r_write <= 1'b0;
            end
            if (r_state == RDCAP) r_rdata <= w_ext;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed load/store vectors checked every cycle against a transaction-level model
module tb_mem_access_unit;
    logic        clk = 1'b0, reset = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [31:0] address, writedata, readdata = 32'hDEADBEEF, resp_rdata;
    logic        read, write, waitrequest = 1'b0, resp_valid, resp_err;
    logic [3:0]  byteenable;

    mem_access_unit dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .address(address), .read(read),
        .write(write), .waitrequest(waitrequest), .byteenable(byteenable),
        .writedata(writedata), .readdata(readdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    int errs = 0, checks = 0, cyc = 0;
    logic [31:0] bus_mem [16];
    logic [31:0] mdl_mem [16];

    // expectation of the transaction currently in flight
    bit          act = 0, e_w, e_legal;
    logic [31:0] e_addr, e_wd, e_rd;
    logic [3:0]  e_be;
    int          acc, stl_g, lat;
    bit          resp_seen = 0, last_err;
    logic [31:0] last_rdata;
    bit          prev_hold = 0;
    int          prev_acc, prev_lat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] off);
        int nb = 1 << sz;
        return 4'(((1 << nb) - 1) << off);
    endfunction

    function automatic logic [31:0] m_lanes(input logic [1:0] sz, input logic [31:0] d);
        int nb = 1 << sz;
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_ext(input logic [31:0] word, input logic [1:0] sz,
                                          input logic [1:0] off, input bit sg);
        int nb = 1 << sz;
        logic [31:0] v = word >> (8 * off);
        logic [31:0] mask;
        if (nb < 4) begin
            mask = (32'h1 << (8 * nb)) - 32'h1;
            v = v & mask;
            if (sg && v[8*nb-1]) v = v | ~mask;
        end
        return v;
    endfunction

    // Responder: one-cycle read latency, garbage on readdata otherwise
    always @(posedge clk) begin
        readdata <= (read && !waitrequest) ? bus_mem[address[5:2]] : 32'hDEADBEEF;
        if (write && !waitrequest)
            for (int i = 0; i < 4; i++)
                if (byteenable[i]) bus_mem[address[5:2]][8*i +: 8] <= writedata[8*i +: 8];
    end

    // Per-cycle comparison of all DUT outputs against the model's expectation
    always @(negedge clk) begin
        bit in_bus, in_txn, is_resp;
        in_bus  = act && e_legal && cyc >= acc && cyc <= acc + stl_g;
        in_txn  = act && cyc >= acc && cyc <= acc + lat - 1;
        is_resp = act && cyc == acc + lat - 1;
        chk("req_ready", {31'b0, req_ready}, {31'b0, reset && !in_txn});
        chk("read", {31'b0, read}, {31'b0, in_bus && !e_w});
        chk("write", {31'b0, write}, {31'b0, in_bus && e_w});
        chk("resp_valid", {31'b0, resp_valid}, {31'b0, is_resp});
        if (in_bus) begin
            chk("address", address, e_addr);
            chk("byteenable", {28'b0, byteenable}, {28'b0, e_be});
            if (e_w) chk("writedata", writedata, e_wd);
        end
        if (is_resp) begin
            chk("resp_err", {31'b0, resp_err}, {31'b0, !e_legal});
            chk("resp_rdata", resp_rdata, e_rd);
            resp_seen  = resp_valid;
            last_rdata = resp_rdata;
            last_err   = resp_err;
        end
        if (!reset) begin
            chk("rst_address", address, 32'h0);
            chk("rst_byteenable", {28'b0, byteenable}, 32'h0);
            chk("rst_writedata", writedata, 32'h0);
            chk("rst_resp_rdata", resp_rdata, 32'h0);
            chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
        end
    end

    task automatic run(input bit w, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                       input logic [31:0] d, input int stl, input bit hold,
                       input logic [31:0] lit, input bit lerr, input int abort);
        int n = 0;
        bit legal = (sz != 2'b11) && (int'(a[1:0]) % (1 << sz) == 0);
        @(negedge clk);
        req_valid = 1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = d;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        chk("accept", {31'b0, req_ready}, 32'h1);
        if (!req_ready) begin req_valid = 0; return; end
        @(posedge clk); #1;
        if (prev_hold) chk("b2b_gap", 32'(cyc - prev_acc), 32'(prev_lat + 1));
        e_w = w; e_legal = legal; e_addr = {a[31:2], 2'b00};
        e_be = legal ? m_be(sz, a[1:0]) : 4'h0;
        e_wd = legal ? m_lanes(sz, d) : 32'h0;
        e_rd = (legal && !w) ? m_ext(mdl_mem[a[5:2]], sz, a[1:0], sg) : 32'h0;
        acc = cyc; stl_g = stl; lat = !legal ? 1 : (w ? 2 : 3) + stl; act = 1;
        if (!hold) req_valid = 0;
        waitrequest = legal && stl > 0;
        if (abort > 0) begin
            repeat (abort) @(posedge clk);
            #3 reset = 0; act = 0;
            #1 chk("abort_read", {31'b0, read}, 32'h0);
            chk("abort_write", {31'b0, write}, 32'h0);
            repeat (3) @(negedge clk);
            #1 reset = 1; waitrequest = 0; prev_hold = 0;
            return;
        end
        while (cyc < acc + lat - 1) begin
            @(posedge clk); #1;
            waitrequest = legal && (cyc - acc) < stl;
        end
        @(negedge clk); #1;
        chk("resp_seen", {31'b0, resp_seen}, 32'h1);
        chk("lit_rdata", last_rdata, lit);
        chk("lit_err", {31'b0, last_err}, {31'b0, lerr});
        resp_seen = 0;
        prev_hold = hold; prev_acc = acc; prev_lat = lat;
        if (legal && w)
            for (int i = 0; i < 4; i++)
                if (e_be[i]) mdl_mem[a[5:2]][8*i +: 8] = e_wd[8*i +: 8];
    endtask

    initial begin
        #200000 $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin bus_mem[i] = '0; mdl_mem[i] = '0; end
        bus_mem[0] = 32'h8001ABCD; mdl_mem[0] = 32'h8001ABCD;
        bus_mem[4] = 32'h80FF1234; mdl_mem[4] = 32'h80FF1234;
        repeat (3) @(negedge clk);
        #1 reset = 1;
        //  w  size   sg addr        data          stl hold literal       err abort
        run(0, 2'b00, 1, 32'h13, 32'h0,          0, 0, 32'hFFFFFF80, 0, 0);
        run(0, 2'b00, 0, 32'h13, 32'h0,          0, 0, 32'h00000080, 0, 0);
        run(0, 2'b01, 0, 32'h00, 32'h0,          0, 0, 32'h0000ABCD, 0, 0);
        run(0, 2'b00, 1, 32'h01, 32'h0,          1, 0, 32'hFFFFFFAB, 0, 0);
        run(1, 2'b10, 0, 32'h10, 32'hAABBCCDD,   0, 0, 32'h0,        0, 0);
        run(0, 2'b10, 0, 32'h10, 32'h0,          2, 0, 32'hAABBCCDD, 0, 0);
        run(1, 2'b01, 0, 32'h22, 32'h0000CCDD,   3, 0, 32'h0,        0, 0);
        run(0, 2'b10, 0, 32'h20, 32'h0,          0, 0, 32'hCCDD0000, 0, 0);
        run(0, 2'b10, 0, 32'h06, 32'h0,          0, 0, 32'h0,        1, 0);
        run(0, 2'b01, 1, 32'h01, 32'h0,          0, 0, 32'h0,        1, 0);
        run(1, 2'b11, 0, 32'h40, 32'h12345678,   0, 0, 32'h0,        1, 0);
        run(0, 2'b01, 1, 32'h02, 32'h0,         20, 0, 32'h0,        0, 2);
        run(0, 2'b01, 1, 32'h02, 32'h0,          0, 0, 32'hFFFF8001, 0, 0);
        run(1, 2'b10, 0, 32'h30, 32'h11223344,   0, 1, 32'h0,        0, 0);
        run(0, 2'b10, 0, 32'h30, 32'h0,          0, 0, 32'h11223344, 0, 0);
        run(1, 2'b00, 0, 32'h31, 32'h000000EE,   1, 0, 32'h0,        0, 0);
        run(0, 2'b10, 0, 32'h30, 32'h0,          0, 0, 32'h1122EE44, 0, 0);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
